uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, the clock cycles per serial bit; legal range is 1 to 65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: request to send a frame; sampled only in IDLE.
REQ-006 SHALL have port txdata, input, DATA_WIDTH bits: the payload, sent LSB first.
REQ-007 SHALL have port parity, input, 1 bit: the parity bit from the upstream parity generator, valid together with load.
REQ-008 SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE with load=1, SHALL latch txdata and parity into internal registers on that edge and move to START.
- Later changes to txdata and parity SHALL NOT affect the frame in flight.
REQ-013 Output values per state SHALL be:
- START: tx=0.
- DATA: tx=shift_reg[0].
- PARITY: tx=latched parity.
- STOP: tx=1.
- IDLE: tx=1.
REQ-014 Every state except IDLE SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts at 0 on each state or bit change.
REQ-015 DATA SHALL emit DATA_WIDTH bits, LSB first, tracked by a bit index counter.
- Shift right by one at the end of each bit period.
- Leave DATA after bit index DATA_WIDTH-1.
REQ-016 SHALL follow the transitions START→DATA→PARITY→STOP→IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
- busy therefore rises on the cycle after load is accepted.
REQ-018 On the edge that ends the STOP period, the FSM SHALL enter IDLE and done SHALL be 1 for exactly that one cycle.
REQ-019 load asserted in the done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-020 load asserted while busy=1 SHALL be ignored entirely: no queuing and no change to the current frame.
REQ-021 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle.
REQ-022 Counter widths SHALL be sized by $clog2 of the parameter, and counters SHALL NOT wrap within a state.

Reset
REQ-023 While rst=1, regardless of clk, the block SHALL hold these values:
- state=IDLE.
- tx=1, busy=0, done=0.
- Counters and shift register at 0.
REQ-024 rst asserted mid-frame SHALL abort the frame, with tx returning to 1 asynchronously.
- After rst is deasserted, the first accepted load SHALL start a fresh frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL exist, and the frame SHALL be 1+DATA_WIDTH+1+1 bits.
REQ-026 Macro UART_TX_PARITY_EN undefined: the PARITY state SHALL be omitted, DATA SHALL go directly to STOP, the parity input SHALL be ignored, and the frame SHALL be 1+DATA_WIDTH+1 bits.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Macro defined, one-cycle load with txdata=8'hA5, parity=0:
- tx SHALL be 0,1,0,1,0,0,1,0,1,0,1, each bit for 4 cycles.
- busy SHALL be high for 44 cycles.
- done SHALL pulse in cycle 45 after load.
REQ-028 Macro undefined, same stimulus:
- tx SHALL be 0,1,0,1,0,0,1,0,1,1 (40 cycles).
- done SHALL pulse in cycle 41.
REQ-029 Load 8'h3C, then at cycle 10 pulse load with 8'hFF:
- The frame SHALL carry 8'h3C only.
- No second frame SHALL follow.
REQ-030 Load 8'h81, then assert rst at cycle 20 for 2 cycles:
- tx=1, busy=0 and done=0 SHALL take effect immediately.
- A new load of 8'h01 SHALL then produce a complete, correct frame.
REQ-031 Load 8'h55, then load 8'hAA in the done cycle:
- The 8'hAA start bit SHALL begin on the next cycle.
- The two frames SHALL be contiguous.
REQ-032 With CLKS_PER_BIT=1, load 8'h01 with parity=1:
- tx SHALL be 0,1,0,0,0,0,0,0,0,1,1, one cycle per bit.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer -- serialises one parallel word into an asynchronous serial frame:
//   start bit (0), DATA_WIDTH payload bits LSB first, optional parity bit, stop bit (1).
//
// Build option:
//   UART_TX_PARITY_EN  defined   : the latched parity bit is sent between data and stop.
//                      undefined : no parity state; the parity input is ignored.
//
// Parameters:
//   DATA_WIDTH    payload bits per frame
//   CLKS_PER_BIT  clock cycles per serial bit (1..65535)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   load    in   frame request, only looked at while idle
//   txdata  in   payload, latched when load is accepted
//   parity  in   parity bit, latched together with txdata
//   tx      out  serial line, idle high
//   busy    out  high while a frame is in progress
//   done    out  one-cycle pulse on the cycle the line returns to idle
module uart_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] txdata,
  input  logic                  parity,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  // A one-cycle bit still needs a 1-bit counter to keep the declarations legal.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    done_q, done_d;
  logic                    bit_end;

`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`else
  logic                    unused_parity;
  assign unused_parity = parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // The bit counter advances inside a bit period and restarts at every bit boundary,
    // so it never wraps on its own.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = txdata;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = parity;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Returning to IDLE here lets a load in the done cycle start the next
        // frame without an extra idle bit.
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level decoded straight from registered state so reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:  tx = 1'b0;
      DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       parity = 1'b0;
  logic       tx, busy, done;

  logic       load1 = 1'b0;
  logic [7:0] txdata1 = 8'h00;
  logic       parity1 = 1'b0;
  logic       tx1, busy1, done1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .load(load), .txdata(txdata), .parity(parity),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .txdata(txdata1), .parity(parity1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Hand model of the frame: index 0 start, 1..8 payload LSB first, then parity/stop.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return p;
`endif
    return 1'b1;
  endfunction

  // Runs one frame on dut, checking tx/busy/done each cycle.
  // preloaded: load was already raised by the previous call in its done cycle.
  // inj_cyc:   cycle at which a second load is pulsed mid-frame (0 = none).
  // abort_cyc: cycle at which rst is raised for two cycles (0 = none).
  // chain:     raise load with chain_d in the done cycle.
  task automatic frame(input logic [7:0] d, input logic p, input bit preloaded,
                       input int inj_cyc, input logic [7:0] inj_d, input int abort_cyc,
                       input bit chain, input logic [7:0] chain_d);
    if (!preloaded) begin
      @(negedge clk);
      load = 1'b1; txdata = d; parity = p;
    end
    @(posedge clk);
    #1;
    load = 1'b0; txdata = ~d; parity = ~p;
    for (int c = 1; c <= NBITS*CPB; c++) begin
      @(negedge clk);
      chk_eq($sformatf("tx %02h c%0d", d, c), tx, exp_bit(d, p, (c-1)/CPB));
      chk_eq($sformatf("busy %02h c%0d", d, c), busy, 1'b1);
      chk_eq($sformatf("done %02h c%0d", d, c), done, 1'b0);
      if (c == inj_cyc) begin
        load = 1'b1; txdata = inj_d; parity = 1'b1;
      end
      if (inj_cyc != 0 && c == inj_cyc + 1) load = 1'b0;
      if (c == abort_cyc) begin
        rst = 1'b1;
        #1;
        chk_eq("abort tx", tx, 1'b1);
        chk_eq("abort busy", busy, 1'b0);
        chk_eq("abort done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_eq("abort hold tx", tx, 1'b1);
        chk_eq("abort hold busy", busy, 1'b0);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk_eq($sformatf("done pulse %02h", d), done, 1'b1);
    chk_eq($sformatf("done busy %02h", d), busy, 1'b0);
    chk_eq($sformatf("done tx %02h", d), tx, 1'b1);
    if (chain) begin
      load = 1'b1; txdata = chain_d; parity = 1'b0;
    end
  endtask

  initial begin
    // Reset values while rst is held.
    #12;
    chk_eq("rst tx", tx, 1'b1);
    chk_eq("rst busy", busy, 1'b0);
    chk_eq("rst done", done, 1'b0);
    chk_eq("rst tx1", tx1, 1'b1);
    chk_eq("rst busy1", busy1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle tx", tx, 1'b1);
    chk_eq("idle busy", busy, 1'b0);

    // Basic frame 8'hA5, parity 0.
    frame(8'hA5, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk_eq("done width", done, 1'b0);

    // A load during the frame is ignored; no second frame follows.
    frame(8'h3C, 1'b1, 1'b0, 10, 8'hFF, 0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq($sformatf("no 2nd tx i%0d", i), tx, 1'b1);
      chk_eq($sformatf("no 2nd busy i%0d", i), busy, 1'b0);
    end

    // Abort with reset mid-frame, then a fresh frame.
    frame(8'h81, 1'b0, 1'b0, 0, 8'h00, 20, 1'b0, 8'h00);
    @(negedge clk);
    chk_eq("post rst idle", busy, 1'b0);
    frame(8'h01, 1'b1, 1'b0, 0, 8'h00, 0, 1'b0, 8'h00);

    // Back-to-back frames: load in the done cycle.
    frame(8'h55, 1'b0, 1'b0, 0, 8'h00, 0, 1'b1, 8'hAA);
    frame(8'hAA, 1'b0, 1'b1, 0, 8'h00, 0, 1'b0, 8'h00);

    // One-cycle bits on the second instance.
    @(negedge clk);
    load1 = 1'b1; txdata1 = 8'h01; parity1 = 1'b1;
    @(posedge clk);
    #1;
    load1 = 1'b0; txdata1 = 8'hFE; parity1 = 1'b0;
    for (int c = 0; c < NBITS; c++) begin
      @(negedge clk);
      chk_eq($sformatf("cpb1 tx b%0d", c), tx1, exp_bit(8'h01, 1'b1, c));
      chk_eq($sformatf("cpb1 busy b%0d", c), busy1, 1'b1);
    end
    @(negedge clk);
    chk_eq("cpb1 done", done1, 1'b1);
    chk_eq("cpb1 idle tx", tx1, 1'b1);
    @(negedge clk);
    chk_eq("cpb1 done width", done1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
